// File: rtl/mem_channel_requester_if.sv
// Bundle between the per-channel command sources, the external arbiter and the issue port.
// The requester uses the slave view; the environment drives the design through the master view.
interface mem_channel_requester_if #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 16
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]        cmd_valid;
  logic [CHANNELS-1:0]        cmd_ready;
  logic [CHANNELS*ADDR_W-1:0] cmd_addr;
  logic [CHANNELS-1:0]        cmd_we;
  logic [CHANNELS-1:0]        req;
  logic [CHANNELS-1:0]        grant;
  logic                       issue_valid;
  logic [CH_W-1:0]            issue_chan;
  logic [ADDR_W-1:0]          issue_addr;
  logic                       issue_we;
  logic [CHANNELS-1:0]        starve;
  logic                       err_multi_grant;
  logic                       spurious_grant;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_we, grant,
    output cmd_ready, req, issue_valid, issue_chan, issue_addr, issue_we,
           starve, err_multi_grant, spurious_grant
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_we, grant,
    input  cmd_ready, req, issue_valid, issue_chan, issue_addr, issue_we,
           starve, err_multi_grant, spurious_grant
  );
endinterface

// File: rtl/mem_channel_requester.sv
// Per-channel command FIFOs feeding an external registered arbiter; pops the lowest-index
// valid grant each cycle and reports issues, grant protocol errors and channel starvation.
module mem_channel_requester #(
  parameter int CHANNELS     = 4,
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input logic                    clk,
  input logic                    rst_n,
  mem_channel_requester_if.slave bus
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] r_memAddr [CHANNELS][DEPTH];
  logic [DEPTH-1:0]  r_memWe   [CHANNELS];
  logic [PTR_W-1:0]  r_wrPtr   [CHANNELS];
  logic [PTR_W-1:0]  r_rdPtr   [CHANNELS];
  logic [CNT_W-1:0]  r_count   [CHANNELS];
  logic [WAIT_W-1:0] r_wait    [CHANNELS];

  logic              r_issueValid;
  logic [CH_W-1:0]   r_issueChan;
  logic [ADDR_W-1:0] r_issueAddr;
  logic              r_issueWe;
  logic              r_errMulti;
  logic              r_spurious;

  logic [CHANNELS-1:0] w_nonEmpty;
  logic [CHANNELS-1:0] w_notFull;
  logic [CHANNELS-1:0] w_starve;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_grantOk;
  logic [CHANNELS-1:0] w_accept;
  logic                w_accAny;
  logic [CH_W-1:0]     w_accIdx;

  always_comb begin
    w_nonEmpty = '0;
    w_notFull  = '0;
    w_starve   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_nonEmpty[i] = (r_count[i] != '0);
      w_notFull[i]  = (r_count[i] != FULL);
      w_starve[i]   = (r_wait[i] == WAIT_MAX);
    end
  end

  // Ready and request come only from registered counts, so there is no path from grant.
  assign bus.cmd_ready = {CHANNELS{rst_n}} & w_notFull;
  assign bus.req       = w_nonEmpty;
  assign bus.starve    = w_starve;
  assign w_push        = bus.cmd_valid & bus.cmd_ready;
  assign w_grantOk     = bus.grant & w_nonEmpty;

  always_comb begin
    w_accept = '0;
    w_accAny = 1'b0;
    w_accIdx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grantOk[i] && !w_accAny) begin
        w_accAny    = 1'b1;
        w_accIdx    = CH_W'(i);
        w_accept[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_push[i]) begin
        r_memAddr[i][r_wrPtr[i]] <= bus.cmd_addr[i*ADDR_W +: ADDR_W];
        r_memWe[i][r_wrPtr[i]]   <= bus.cmd_we[i];
      end
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_count[i] <= '0;
        r_wait[i]  <= '0;
      end
      r_issueValid <= 1'b0;
      r_issueChan  <= '0;
      r_issueAddr  <= '0;
      r_issueWe    <= 1'b0;
      r_errMulti   <= 1'b0;
      r_spurious   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_push[i]) begin
          r_wrPtr[i] <= r_wrPtr[i] + 1'b1;
        end
        if (w_accept[i]) begin
          r_rdPtr[i] <= r_rdPtr[i] + 1'b1;
        end
        case ({w_push[i], w_accept[i]})
          2'b10:   r_count[i] <= r_count[i] + 1'b1;
          2'b01:   r_count[i] <= r_count[i] - 1'b1;
          default: r_count[i] <= r_count[i];
        endcase
        if (w_nonEmpty[i] && !w_accept[i]) begin
          if (r_wait[i] != WAIT_MAX) begin
            r_wait[i] <= r_wait[i] + 1'b1;
          end
        end else begin
          r_wait[i] <= '0;
        end
      end
      r_issueValid <= w_accAny;
      if (w_accAny) begin
        r_issueChan <= w_accIdx;
        r_issueAddr <= r_memAddr[w_accIdx][r_rdPtr[w_accIdx]];
        r_issueWe   <= r_memWe[w_accIdx][r_rdPtr[w_accIdx]];
      end
      r_errMulti <= ($countones(bus.grant) > 1);
      r_spurious <= |(bus.grant & ~w_nonEmpty);
    end
  end

  assign bus.issue_valid     = r_issueValid;
  assign bus.issue_chan      = r_issueChan;
  assign bus.issue_addr      = r_issueAddr;
  assign bus.issue_we        = r_issueWe;
  assign bus.err_multi_grant = r_errMulti;
  assign bus.spurious_grant  = r_spurious;
endmodule

// File: doc/mem_channel_requester.md
MEM_CHANNEL_REQUESTER -- requirements
Module: mem_channel_requester

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of requesting channels, matches arbiter width.
REQ-002 SHALL have parameter ADDR_W, default 16: command address width.
REQ-003 SHALL have parameter DEPTH, default 4 (power of 2, >=2): per-channel command FIFO depth.
REQ-004 SHALL have parameter STARVE_LIMIT, default 15: wait cycles before starvation flag.
REQ-005 SHALL use one clock and a synchronous, active-low reset, named as the codebase does:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
REQ-006 SHALL have these remaining ports:
- cmd_valid  in  CHANNELS  per-channel command present
- cmd_ready  out  CHANNELS  per-channel FIFO can accept
- cmd_addr  in  CHANNELS*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- cmd_we  in  CHANNELS  per-channel write flag
- req  out  CHANNELS  request to arbiter
- grant  in  CHANNELS  grant from arbiter (registered on arbiter side)
- issue_valid  out  1  one-cycle pulse per issued command
- issue_chan  out  $clog2(CHANNELS)  channel of issued command
- issue_addr  out  ADDR_W  address of issued command
- issue_we  out  1  write flag of issued command
- starve  out  CHANNELS  per-channel starvation flag
- err_multi_grant  out  1  one-cycle pulse, >1 grant bit seen
- spurious_grant  out  1  one-cycle pulse, grant to empty channel

Function
REQ-007 SHALL keep one FIFO per channel (DEPTH entries of {addr, we}) with occupancy count 0..DEPTH.
REQ-008 SHALL drive cmd_ready[i] = rst_n & (count[i] != DEPTH), from registered count only.
REQ-009 SHALL push on cmd_valid[i] & cmd_ready[i]; entry is visible to req at the next cycle.
REQ-010 SHALL drive req[i] = (count[i] != 0), from registered state, no combinational path from grant.
REQ-011 SHALL accept a grant in cycle t only if grant[i]=1 and count[i]!=0; if several such bits, accept lowest index only.
REQ-012 SHALL pop accepted channel's head at end of cycle t; issue_valid=1 in cycle t+1 with issue_chan/addr/we of popped entry; one cycle latency.
REQ-013 SHALL hold issue_valid=0 when no grant accepted; issue_chan/addr/we hold last value then.
REQ-014 SHALL pulse err_multi_grant in t+1 when popcount(grant) > 1 in t, regardless of FIFO state; non-accepted granted channels are not popped.
REQ-015 SHALL pulse spurious_grant in t+1 when any grant[i]=1 with count[i]=0 in t (expected one cycle after a last-entry pop, since arbiter is registered); no pop, no issue.
REQ-016 SHALL handle simultaneous push and pop on one channel: both occur, count unchanged, FIFO order preserved.
REQ-017 SHALL not push when full even if a pop occurs same cycle (cmd_ready from registered count).
REQ-018 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-019 SHALL keep per-channel wait counter: +1 (saturating at STARVE_LIMIT) each cycle req[i]=1 and channel i not accepted; cleared on acceptance or when req[i]=0.
REQ-020 SHALL set starve[i]=1 while wait counter == STARVE_LIMIT; clears the cycle after acceptance.

Reset
REQ-021 SHALL, on rst_n=0 at a rising edge, clear all counts, pointers, wait counters; issue_valid=0, issue_chan=0, issue_addr=0, issue_we=0, starve=0, err_multi_grant=0, spurious_grant=0; req=0; cmd_ready=0 while rst_n=0.
REQ-022 SHALL discard all queued commands on reset mid-operation; no issue pulse in cycle after reset; grant ignored while rst_n=0.
REQ-023 SHALL raise cmd_ready to all-ones the first cycle with rst_n=1.

Verification
REQ-024 SHALL cover: push ch2 addr 0x1234 we=1; grant=0100 two cycles later -> issue_valid 1 cycle, issue_chan=2, issue_addr=0x1234, issue_we=1; req[2] falls same cycle.
REQ-025 SHALL cover: push 4 entries ch0, 5th held -> cmd_ready[0]=0; grant pops 1 -> cmd_ready[0]=1 next cycle; order 0xA0..0xA3 preserved on issue.
REQ-026 SHALL cover: ch1 and ch3 non-empty, grant=1010 (pass-through) -> ch1 issued, ch3 count unchanged, err_multi_grant pulses once.
REQ-027 SHALL cover: single entry ch0, grant held 2 cycles -> one issue, spurious_grant pulse in second cycle after grant.
REQ-028 SHALL cover: ch3 requesting, no grant 15 cycles -> starve[3]=1 at cycle 15; grant -> starve[3]=0 next cycle.
REQ-029 SHALL cover: rst_n low for 1 cycle with 3 entries queued on ch1 -> req=0, count 0, no issue afterwards, cmd_ready=1111.
